// File: rtl/a_b_alu.sv
// a_b_alu: accumulator (A), operand (B) and add/subtract ALU on a shared tri-state bus.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   clear      - synchronous active-low reset (A, B and flags to 0)
//   bus        - shared system bus; driven only when write_a or write_alu is high
//   load_a     - capture bus into A on the next rising edge
//   write_a    - drive A onto the bus (combinational, wins over write_alu)
//   load_b     - capture bus into B on the next rising edge
//   write_alu  - drive ALU result onto the bus; also enables the flag update
//   enable_sub - 0: A+B, 1: A-B
//   a_value    - current A contents
//   b_value    - current B contents
//   carry_flag - carry-out of the last latched ALU operation (1 = no borrow on subtract)
//   zero_flag  - result==0 of the last latched ALU operation
module a_b_alu #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear,
   inout  wire  [WIDTH-1:0] bus,
   input  logic             load_a,
   input  logic             write_a,
   input  logic             load_b,
   input  logic             write_alu,
   input  logic             enable_sub,
   output logic [WIDTH-1:0] a_value,
   output logic [WIDTH-1:0] b_value,
   output logic             carry_flag,
   output logic             zero_flag
);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] b_opnd;
   logic [WIDTH:0]   alu_sum;
   logic [WIDTH-1:0] alu_r;
   logic             alu_c;
   logic             flag_update;

   // Subtract as A + ~B + 1 so the carry-out reads as "no borrow".
   always_comb begin
      b_opnd  = enable_sub ? ~b_q : b_q;
      alu_sum = {1'b0, a_q} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, enable_sub};
   end

   assign alu_r = alu_sum[WIDTH-1:0];
   assign alu_c = alu_sum[WIDTH];

   // write_a wins, so the block never drives two sources at once.
   assign bus = write_a   ? a_q   :
                write_alu ? alu_r : {WIDTH{1'bz}};

   // Flags follow only a result that actually reached the bus.
   assign flag_update = write_alu & ~write_a;

   always_comb begin
      a_d     = load_a ? bus : a_q;
      b_d     = load_b ? bus : b_q;
      carry_d = flag_update ? alu_c : carry_q;
      zero_d  = flag_update ? (alu_r == '0) : zero_q;
   end

   always_ff @(posedge clk) begin
      if (!clear) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   assign a_value    = a_q;
   assign b_value    = b_q;
   assign carry_flag = carry_q;
   assign zero_flag  = zero_q;

endmodule

// File: tb/tb_a_b_alu.sv
// tb_a_b_alu: directed, table-driven bench for a_b_alu.
module tb_a_b_alu;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         clear;
   wire  [W-1:0] bus;
   logic         load_a, write_a, load_b, write_alu, enable_sub;
   logic [W-1:0] a_value, b_value;
   logic         carry_flag, zero_flag;

   logic         tb_en;
   logic [W-1:0] tb_data;

   assign bus = tb_en ? tb_data : {W{1'bz}};

   int tests = 0;
   int fails = 0;

   a_b_alu #(.WIDTH(W)) dut (
      .clk        (clk),
      .clear      (clear),
      .bus        (bus),
      .load_a     (load_a),
      .write_a    (write_a),
      .load_b     (load_b),
      .write_alu  (write_alu),
      .enable_sub (enable_sub),
      .a_value    (a_value),
      .b_value    (b_value),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] exp_r;
      logic         exp_c;
      logic         exp_z;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tb_en = 1'b0; load_a = 1'b0; load_b = 1'b0;
      write_a = 1'b0; write_alu = 1'b0;
   endtask

   task automatic load_ab(input logic [W-1:0] av, input logic [W-1:0] bv);
      idle();
      tb_en = 1'b1; tb_data = av; load_a = 1'b1;
      tick();
      load_a = 1'b0; tb_data = bv; load_b = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      vecs[0] = '{8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0};
      vecs[1] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b1};
      vecs[2] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
      vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[6] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0};
      vecs[7] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};

      tb_data = '0; enable_sub = 1'b0;
      idle();

      // Reset
      clear = 1'b0;
      tick();
      clear = 1'b1;
      check("reset a_value", a_value, 0);
      check("reset b_value", b_value, 0);
      check("reset carry", carry_flag, 0);
      check("reset zero", zero_flag, 0);
      write_a = 1'b1;
      #1 check("reset bus=A", bus, 8'h00);
      idle();

      // Load / read
      tb_en = 1'b1; tb_data = 8'h2A; load_a = 1'b1;
      tick();
      check("load_a", a_value, 8'h2A);
      load_a = 1'b0; tb_data = 8'h11; load_b = 1'b1;
      tick();
      check("load_b", b_value, 8'h11);
      idle();
      write_a = 1'b1;
      #1 check("write_a bus", bus, 8'h2A);
      // Undriven by DUT: bench value must read back with no contention from A=0x2A.
      idle();
      tb_en = 1'b1; tb_data = 8'hD5;
      #1 check("bus released", bus, 8'hD5);
      idle();
      // write_a + load_b: B <= A
      write_a = 1'b1; load_b = 1'b1;
      tick();
      check("B<=A self-path", b_value, 8'h2A);
      idle();

      // Table-driven ALU vectors
      foreach (vecs[i]) begin
         load_ab(vecs[i].a, vecs[i].b);
         enable_sub = vecs[i].sub;
         write_alu = 1'b1;
         #1 check($sformatf("vec%0d bus", i), bus, vecs[i].exp_r);
         tick();
         check($sformatf("vec%0d carry", i), carry_flag, vecs[i].exp_c);
         check($sformatf("vec%0d zero", i), zero_flag, vecs[i].exp_z);
         idle();
      end

      // Flags hold when write_alu is low (last vector left c=0, z=0)
      load_ab(8'h00, 8'h00);
      enable_sub = 1'b0;
      tick();
      check("hold carry", carry_flag, 0);
      check("hold zero", zero_flag, 0);

      // Accumulate
      load_ab(8'h07, 8'h03);
      enable_sub = 1'b0;
      write_alu = 1'b1; load_a = 1'b1;
      tick();
      check("acc 1", a_value, 8'h0A);
      tick();
      check("acc 2", a_value, 8'h0D);
      tick();
      check("acc 3", a_value, 8'h10);
      idle();
      check("acc carry", carry_flag, 0);
      check("acc zero", zero_flag, 0);

      // Priority: write_a beats write_alu, flags stay, A unchanged with load_a
      load_ab(8'h05, 8'h05);
      enable_sub = 1'b1;
      write_a = 1'b1; write_alu = 1'b1; load_a = 1'b1;
      #1 check("priority bus", bus, 8'h05);
      tick();
      check("priority carry", carry_flag, 0);
      check("priority zero", zero_flag, 0);
      check("write_a+load_a", a_value, 8'h05);
      idle();

      // Set flags, then reset in the middle of a load
      write_alu = 1'b1;
      tick();
      check("pre-reset carry", carry_flag, 1);
      check("pre-reset zero", zero_flag, 1);
      idle();
      tb_en = 1'b1; tb_data = 8'h55; load_a = 1'b1; clear = 1'b0;
      tick();
      clear = 1'b1;
      idle();
      check("mid-reset a", a_value, 8'h00);
      check("mid-reset b", b_value, 8'h00);
      check("mid-reset carry", carry_flag, 0);
      check("mid-reset zero", zero_flag, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/a_b_alu.md
Name: a_b_alu

Overview:
- Accumulator (A) register, operand (B) register and add/subtract ALU for the 8-bit bus-based computer.
- Sits on the shared tri-state system bus.
- Loads A and B from the bus and drives either A or the ALU result back onto it under control-word signals.
- Latches carry and zero flags for conditional-jump logic.

Parameters:
WIDTH, 8, data width of bus, A, B and ALU result.

Ports:
clk  input  1  system clock; all state updates on rising edge.
clear  input  1  synchronous, active-low reset.
bus  inout  WIDTH  shared system bus; driven only when write_a or write_alu is high, otherwise high-Z.
load_a  input  1  capture bus into A at next rising edge.
write_a  input  1  drive A onto bus (combinational).
load_b  input  1  capture bus into B at next rising edge.
write_alu  input  1  drive ALU result onto bus (combinational); also enables flag update.
enable_sub  input  1  0: result = A+B; 1: result = A-B.
a_value  output  WIDTH  current A contents (debug/display).
b_value  output  WIDTH  current B contents (debug/display).
carry_flag  output  1  registered carry-out of last latched ALU operation.
zero_flag  output  1  registered result==0 of last latched ALU operation.

Behaviour:
- Reset:
  - On rising clk with clear==0: A=0, B=0, carry_flag=0, zero_flag=0.
  - Reset overrides all loads.
  - Bus drive stays purely combinational and is still controlled by write_a/write_alu during reset.
- Registers (clear==1):
  - load_a=1: A<=bus.
  - load_b=1: B<=bus.
  - Loads are independent; both may fire in the same cycle.
  - Otherwise A and B hold.
- ALU (combinational, WIDTH+1 bits internally):
  - Add: {c,r} = A + B.
  - Sub: {c,r} = A + ~B + 1 (two's complement). c=1 means no borrow (A>=B unsigned).
  - Result wraps modulo 2^WIDTH.
- Bus drive:
  - write_a=1: bus = A.
  - else write_alu=1: bus = r.
  - else bus = Z.
  - write_a has priority when both are high; the block never drives two sources at once.
- Flags:
  - On rising edge with clear==1 and write_alu==1 (and write_a==0): carry_flag<=c, zero_flag<=(r==0).
  - Otherwise flags hold.
- Self-paths, all resolving within one cycle with no combinational loop through registers:
  - write_alu with load_a: A<=r (accumulate).
  - write_a with load_b: B<=A.
  - write_a with load_a: A unchanged.
- Loading while no source drives the bus stores an undefined value; the controller must never do this.
- Latency: bus output changes combinationally with A, B and enable_sub; register/flag updates take effect one edge after the control is sampled.

Test Plan:
- Reset: drive clear=0 for one edge, then write_a=1 -> bus=0x00; flags 0; with all writes low, bus=Z.
- Load/read:
  - bus=0x2A with load_a -> a_value=0x2A.
  - bus=0x11 with load_b -> b_value=0x11.
  - Release the bench driver, assert write_a -> bus=0x2A.
- Add with carry: A=0xF0, B=0x20, enable_sub=0, write_alu -> bus=0x10; after edge carry_flag=1, zero_flag=0.
- Subtract:
  - A=0x05, B=0x05, enable_sub=1 -> bus=0x00; zero_flag=1, carry_flag=1.
  - A=0x03, B=0x05 -> bus=0xFE, carry_flag=0.
- Accumulate: A=0x07, B=0x03, write_alu+load_a for 3 edges -> a_value 0x0A, 0x0D, 0x10.
- Priority and mid-operation reset:
  - write_a and write_alu both high -> bus=A, flags unchanged.
  - clear=0 during load_a with bus=0x55 -> A=0x00.
